rf_port_arbiter: RTL and testbench

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

---
 rtl/rf_port_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter for a register file with a write port and two read ports.
// Round-robin contention, bounded lock ownership, one-cycle registered read valid.
module rf_port_arbiter #(
    parameter int unsigned M        = 3,
    parameter int unsigned N        = 8,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  logic [1:0]       we,
    input  logic [2*M-1:0]   addr_a,
    input  logic [2*M-1:0]   addr_b,
    input  logic [2*N-1:0]   wdata,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [N-1:0]     rdata_a,
    output logic [N-1:0]     rdata_b,
    output logic             rf_write,
    output logic             rf_reada,
    output logic             rf_readb,
    output logic [M-1:0]     rf_waddr,
    output logic [M-1:0]     rf_ra,
    output logic [M-1:0]     rf_rb,
    output logic [N-1:0]     rf_wd,
    input  logic [N-1:0]     rf_qa,
    input  logic [N-1:0]     rf_qb
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ST_OPEN,
        ST_HELD
    } state_e;

    state_e          state_q;
    logic            owner_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic            last_q;
    logic [1:0]      rvalid_q;

    logic            hold_c;
    logic            gnt_vld_c;
    logic            gnt_idx_c;
    logic            sel_we;
    logic [M-1:0]    sel_aa;
    logic [M-1:0]    sel_ab;
    logic [N-1:0]    sel_wd;

    // Keep the owner unless it released, or its lock budget ran out while the other waits.
    always_comb begin
        hold_c    = 1'b0;
        gnt_vld_c = 1'b0;
        gnt_idx_c = 1'b0;
        if (!rst) begin
            hold_c = (state_q == ST_HELD) && req[owner_q] && lock[owner_q] &&
                     !((cnt_q == CW'(LOCK_MAX)) && req[~owner_q]);
            if (hold_c) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = owner_q;
            end else if (req == 2'b11) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = ~last_q;
            end else if (req[0]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = 1'b0;
            end else if (req[1]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + CW'(1);

    assign sel_we = gnt_idx_c ? we[1]              : we[0];
    assign sel_aa = gnt_idx_c ? addr_a[2*M-1:M]    : addr_a[M-1:0];
    assign sel_ab = gnt_idx_c ? addr_b[2*M-1:M]    : addr_b[M-1:0];
    assign sel_wd = gnt_idx_c ? wdata[2*N-1:N]     : wdata[N-1:0];

    assign gnt      = gnt_vld_c ? (gnt_idx_c ? 2'b10 : 2'b01) : 2'b00;
    assign rf_write = gnt_vld_c && sel_we;
    assign rf_reada = gnt_vld_c && !sel_we;
    assign rf_readb = rf_reada;
    assign rf_waddr = rf_write ? sel_aa : '0;
    assign rf_wd    = rf_write ? sel_wd : '0;
    assign rf_ra    = rf_reada ? sel_aa : '0;
    assign rf_rb    = rf_reada ? sel_ab : '0;

    // The register file already registers its read data; pass it straight through.
    assign rdata_a = rf_qa;
    assign rdata_b = rf_qb;
    assign rvalid  = rvalid_q & {2{~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OPEN;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= gnt & ~we;
            if (gnt_vld_c) begin
                last_q <= gnt_idx_c;
            end
            if (gnt_vld_c && lock[gnt_idx_c]) begin
                state_q <= ST_HELD;
                owner_q <= gnt_idx_c;
                cnt_q   <= hold_c ? cnt_inc : CW'(1);
            end else begin
                state_q <= ST_OPEN;
                cnt_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios plus constrained-random traffic
// checked cycle by cycle against a rule-level model of arbitration and memory contents.
module tb_rf_port_arbiter;

    localparam int unsigned M        = 3;
    localparam int unsigned N        = 8;
    localparam int unsigned LOCK_MAX = 4;
    localparam int unsigned DEPTH    = 1 << M;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req, lock, we;
    logic [2*M-1:0] addr_a, addr_b;
    logic [2*N-1:0] wdata;
    logic [1:0]     gnt, rvalid;
    logic [N-1:0]   rdata_a, rdata_b;
    logic           rf_write, rf_reada, rf_readb;
    logic [M-1:0]   rf_waddr, rf_ra, rf_rb;
    logic [N-1:0]   rf_wd, rf_qa, rf_qb;

    always #5 clk = ~clk;

    rf_port_arbiter #(.M(M), .N(N), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
        .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rf_write(rf_write), .rf_reada(rf_reada), .rf_readb(rf_readb),
        .rf_waddr(rf_waddr), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wd(rf_wd),
        .rf_qa(rf_qa), .rf_qb(rf_qb)
    );

    // Register file environment: synchronous write, registered reads.
    logic [N-1:0] rf_mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) rf_mem[k] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_waddr] <= rf_wd;
        end
        if (rf_reada) rf_qa <= rf_mem[rf_ra];
        if (rf_readb) rf_qb <= rf_mem[rf_rb];
    end

    // Reference model state
    int           m_owner, m_streak, m_last;
    logic [N-1:0] m_mem [DEPTH];
    logic [1:0]   exp_rv;
    logic [N-1:0] exp_qa, exp_qb;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           last_g;
    logic [1:0]   obs_gnt, obs_rv;
    logic [N-1:0] obs_qa, obs_qb;
    logic [1:0]   pend;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] aa(input int i);
        return addr_a[i*M +: M];
    endfunction
    function automatic logic [M-1:0] ab(input int i);
        return addr_b[i*M +: M];
    endfunction
    function automatic logic [N-1:0] wd(input int i);
        return wdata[i*N +: N];
    endfunction

    // Who should own the port this cycle, from the arbitration rules (-1 = nobody).
    function automatic int model_pick();
        if (rst) return -1;
        if (m_owner >= 0 && req[m_owner] && lock[m_owner] &&
            !(m_streak >= int'(LOCK_MAX) && req[1-m_owner])) return m_owner;
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        return 1 - m_last;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_streak = 0;
        m_last = 1;
        exp_rv = 2'b00;
        for (int k = 0; k < int'(DEPTH); k++) m_mem[k] = '0;
    endtask

    // One clock cycle: inputs already applied just after a falling edge.
    task automatic step();
        int         g;
        logic [1:0] eg, erv;
        #1;
        g   = model_pick();
        eg  = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
        erv = rst ? 2'b00 : exp_rv;
        obs_gnt = gnt;
        obs_rv  = rvalid;
        obs_qa  = rdata_a;
        obs_qb  = rdata_b;
        check_val("gnt", 32'(gnt), 32'(eg));
        if (g < 0)
            check_val("rf_idle", 32'({rf_write, rf_reada, rf_readb, rf_waddr, rf_ra, rf_rb, rf_wd}), 32'd0);
        else if (we[g])
            check_val("rf_wr", 32'({rf_write, rf_reada, rf_readb, rf_waddr, rf_wd}),
                      32'({3'b100, aa(g), wd(g)}));
        else
            check_val("rf_rd", 32'({rf_write, rf_reada, rf_readb, rf_ra, rf_rb}),
                      32'({3'b011, aa(g), ab(g)}));
        check_val("rvalid", 32'(rvalid), 32'(erv));
        if (erv != 2'b00) begin
            check_val("rdata_a", 32'(rdata_a), 32'(exp_qa));
            check_val("rdata_b", 32'(rdata_b), 32'(exp_qb));
        end
        if (rst) begin
            model_reset();
        end else begin
            exp_rv = 2'b00;
            if (g >= 0) begin
                if (we[g]) begin
                    m_mem[aa(g)] = wd(g);
                end else begin
                    exp_rv = (g == 1) ? 2'b10 : 2'b01;
                    exp_qa = m_mem[aa(g)];
                    exp_qb = m_mem[ab(g)];
                end
                if (lock[g]) begin
                    m_streak = (g == m_owner) ? ((m_streak + 1 > int'(LOCK_MAX)) ? int'(LOCK_MAX) : m_streak + 1) : 1;
                    m_owner  = g;
                end else begin
                    m_owner  = -1;
                    m_streak = 0;
                end
                m_last = g;
            end else begin
                m_owner  = -1;
                m_streak = 0;
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [M-1:0] a, input logic [M-1:0] b, input logic [N-1:0] d);
        req[i] = r;
        lock[i] = l;
        we[i] = w;
        addr_a[i*M +: M] = a;
        addr_b[i*M +: M] = b;
        wdata[i*N +: N] = d;
    endtask

    logic [1:0] pat38 [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

    initial begin
        rst = 1'b1;
        req = '0; lock = '0; we = '0; addr_a = '0; addr_b = '0; wdata = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        check_val("rst_gnt", 32'(obs_gnt), 32'd0);
        rst = 1'b0;

        // Write then cross-requester read of the same address
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 8'hA5);
        set_port(1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
        step();
        check_val("t36_gnt0", 32'(obs_gnt), 32'h1);
        set_port(0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 8'h00);
        step();
        check_val("t36_gnt1", 32'(obs_gnt), 32'h2);
        req = 2'b00;
        step();
        check_val("t36_rv", 32'(obs_rv), 32'h2);
        check_val("t36_qa", 32'(obs_qa), 32'hA5);
        check_val("t36_qb", 32'(obs_qb), 32'h00);

        // Unlocked contention alternates
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd4, 8'h00);
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("t37_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) check_val("t37_rv", 32'(obs_rv), (k % 2 == 0) ? 32'h2 : 32'h1);
        end
        req = 2'b00;
        step();
        check_val("t37_rv_last", 32'(obs_rv), 32'h2);

        // Lock expiry hands over for one cycle
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 8'h00);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd4, 8'h00);
        for (int k = 0; k < 9; k++) begin
            step();
            check_val("t38_gnt", 32'(obs_gnt), 32'(pat38[k]));
        end
        req = 2'b00; lock = 2'b00;
        step();

        // Locked sole requester keeps the port
        set_port(0, 1'b1, 1'b1, 1'b0, 3'd5, 3'd6, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("t39_gnt", 32'(obs_gnt), 32'h1);
        end
        req = 2'b00; lock = 2'b00;
        step();

        // Reset with a read in flight
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 8'h00);
        step();
        check_val("t40_gnt1", 32'(obs_gnt), 32'h2);
        rst = 1'b1;
        step();
        check_val("t40_rst_rv", 32'(obs_rv), 32'h0);
        check_val("t40_rst_gnt", 32'(obs_gnt), 32'h0);
        step();
        check_val("t40_rst_rv2", 32'(obs_rv), 32'h0);
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 8'h00);
        step();
        check_val("t40_post_gnt", 32'(obs_gnt), 32'h1);
        check_val("t40_post_rv", 32'(obs_rv), 32'h0);
        req = 2'b10;
        step();
        req = 2'b00;
        step();

        // Read right after write to the same address
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 8'h3C);
        step();
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 8'h00);
        step();
        req = 2'b00;
        step();
        check_val("t41_rv", 32'(obs_rv), 32'h1);
        check_val("t41_qa", 32'(obs_qa), 32'h3C);

        // Constrained-random traffic honouring the hold-until-granted rule
        pend = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    req[i]  = ($urandom_range(0, 3) != 0);
                    we[i]   = ($urandom_range(0, 2) == 0);
                    lock[i] = (c >= 700) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                    addr_a[i*M +: M] = M'($urandom);
                    addr_b[i*M +: M] = M'($urandom);
                    wdata[i*N +: N]  = N'($urandom);
                end
            end
            step();
            for (int i = 0; i < 2; i++) pend[i] = req[i] && (last_g != i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
